// File: rtl/ysyx_041514_mem_arbiter.sv
// rtl/ysyx_041514_mem_arbiter.sv - shares the NPC memory port between IF and LSU
`timescale 1ns/1ps

module ysyx_041514_mem_arbiter #(
  parameter int XLEN        = 64,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_rdata_valid_o,
  output logic [XLEN-1:0]   if_rdata_o,
  output logic              if_err_o,
  input  logic              ls_req_valid_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [XLEN-1:0]   ls_wdata_i,
  input  logic [7:0]        ls_mask_i,
  output logic              ls_done_o,
  output logic [XLEN-1:0]   ls_rdata_o,
  output logic              ls_err_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic [7:0]        mem_mask_o,
  input  logic              mem_resp_valid_i,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYC - 1);

  logic [1:0]        state_q, state_d;
  logic              ls_owner_q, ls_owner_d;
  logic              drop_q, drop_d;
  logic              mask_if_q, mask_if_d;
  logic              mask_ls_q, mask_ls_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [7:0]        bmask_q, bmask_d;
  logic              if_valid_q, if_valid_d;
  logic [XLEN-1:0]   if_rdata_q, if_rdata_d;
  logic              if_err_q, if_err_d;
  logic              ls_done_q, ls_done_d;
  logic [XLEN-1:0]   ls_rdata_q, ls_rdata_d;
  logic              ls_err_q, ls_err_d;
  logic              grant_ls, grant_if, flush_own, timeout;

  always_comb begin
    state_d    = state_q;
    ls_owner_d = ls_owner_q;
    drop_d     = drop_q;
    mask_if_d  = 1'b0;
    mask_ls_d  = 1'b0;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    bmask_d    = bmask_q;
    if_valid_d = 1'b0;
    if_rdata_d = if_rdata_q;
    if_err_d   = 1'b0;
    ls_done_d  = 1'b0;
    ls_rdata_d = ls_rdata_q;
    ls_err_d   = 1'b0;
    timeout    = 1'b0;
    // The requester that just completed sits out one arbitration round.
    grant_ls   = ls_req_valid_i && !mask_ls_q;
    grant_if   = if_req_valid_i && !if_flush_i && !mask_if_q;
    flush_own  = !ls_owner_q && if_flush_i;
    case (state_q)
      S_IDLE: begin
        if (grant_ls) begin
          state_d    = S_REQ;
          ls_owner_d = 1'b1;
          drop_d     = 1'b0;
          addr_d     = ls_addr_i;
          we_d       = ls_we_i;
          wdata_d    = ls_wdata_i;
          bmask_d    = ls_mask_i;
        end else if (grant_if) begin
          state_d    = S_REQ;
          ls_owner_d = 1'b0;
          drop_d     = 1'b0;
          addr_d     = if_addr_i;
          we_d       = 1'b0;
          wdata_d    = '0;
          bmask_d    = 8'h0f;
        end
      end
      S_REQ: begin
        if (flush_own) drop_d = 1'b1;
        if (mem_req_ready_i) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (flush_own) drop_d = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        timeout = !mem_resp_valid_i && (cnt_q == LAST_WAIT);
        if (mem_resp_valid_i || timeout) begin
          state_d = S_IDLE;
          if (ls_owner_q) begin
            mask_ls_d  = 1'b1;
            ls_done_d  = 1'b1;
            ls_err_d   = timeout;
            ls_rdata_d = (timeout || we_q) ? '0 : mem_rdata_i;
          end else begin
            mask_if_d = 1'b1;
            // A redirected fetch still drains downstream but is never reported.
            if (!drop_d) begin
              if_valid_d = 1'b1;
              if_err_d   = timeout;
              if_rdata_d = timeout ? '0 : mem_rdata_i;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ls_owner_q <= 1'b0;
      drop_q     <= 1'b0;
      mask_if_q  <= 1'b0;
      mask_ls_q  <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      bmask_q    <= '0;
      if_valid_q <= 1'b0;
      if_rdata_q <= '0;
      if_err_q   <= 1'b0;
      ls_done_q  <= 1'b0;
      ls_rdata_q <= '0;
      ls_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ls_owner_q <= ls_owner_d;
      drop_q     <= drop_d;
      mask_if_q  <= mask_if_d;
      mask_ls_q  <= mask_ls_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      bmask_q    <= bmask_d;
      if_valid_q <= if_valid_d;
      if_rdata_q <= if_rdata_d;
      if_err_q   <= if_err_d;
      ls_done_q  <= ls_done_d;
      ls_rdata_q <= ls_rdata_d;
      ls_err_q   <= ls_err_d;
    end
  end

  assign mem_req_valid_o  = (state_q == S_REQ);
  assign mem_addr_o       = addr_q;
  assign mem_we_o         = we_q;
  assign mem_wdata_o      = wdata_q;
  assign mem_mask_o       = bmask_q;
  assign if_rdata_valid_o = if_valid_q;
  assign if_rdata_o       = if_rdata_q;
  assign if_err_o         = if_err_q;
  assign ls_done_o        = ls_done_q;
  assign ls_rdata_o       = ls_rdata_q;
  assign ls_err_o         = ls_err_q;

endmodule

// File: tb/tb_ysyx_041514_mem_arbiter.sv
// tb/tb_ysyx_041514_mem_arbiter.sv - vector table, directed corners and random run vs reference model
`timescale 1ns/1ps

module tb_ysyx_041514_mem_arbiter;
  localparam int TIMEOUT = 255;
  localparam logic [31:0] IA  = 32'h8000_0000;
  localparam logic [31:0] IA8 = 32'h8000_0008;
  localparam logic [31:0] IB  = 32'h8000_0010;
  localparam logic [31:0] IC  = 32'h8000_0100;
  localparam logic [31:0] ZA  = 32'h0;
  localparam logic [63:0] Z   = 64'h0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, if_req_valid_i, if_flush_i, if_rdata_valid_o, if_err_o;
  logic [31:0] if_addr_i, ls_addr_i, mem_addr_o;
  logic [63:0] if_rdata_o, ls_wdata_i, ls_rdata_o, mem_wdata_o, mem_rdata_i;
  logic ls_req_valid_i, ls_we_i, ls_done_o, ls_err_o;
  logic [7:0] ls_mask_i, mem_mask_o;
  logic mem_req_valid_o, mem_req_ready_i, mem_we_o, mem_resp_valid_i;

  ysyx_041514_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req_valid_i(if_req_valid_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_rdata_valid_o(if_rdata_valid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .ls_req_valid_i(ls_req_valid_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_mask_i(ls_mask_i),
    .ls_done_o(ls_done_o), .ls_rdata_o(ls_rdata_o), .ls_err_o(ls_err_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
    .mem_mask_o(mem_mask_o), .mem_resp_valid_i(mem_resp_valid_i), .mem_rdata_i(mem_rdata_i)
  );

  int total = 0;
  int bad = 0;

  // Reference model: one transaction at a time, timeout measured from the accept cycle.
  bit m_busy = 0, m_ls = 0, m_drop = 0, m_skip_if = 0, m_skip_ls = 0;
  int m_acc = -1;
  int m_cyc = 0;
  logic e_mval = 0, e_mwe = 0, e_ifv = 0, e_ife = 0, e_lsv = 0, e_lse = 0;
  logic [31:0] e_maddr = 0;
  logic [63:0] e_mwd = 0, e_ifd = 0, e_lsd = 0;
  logic [7:0]  e_mmask = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    bit nsi, nsl, tmo;
    nsi = 0; nsl = 0;
    e_ifv = 0; e_ife = 0; e_lsv = 0; e_lse = 0;
    if (rst) begin
      m_busy = 0; m_drop = 0; m_skip_if = 0; m_skip_ls = 0; m_acc = -1;
      e_mval = 0; e_maddr = 0; e_mwe = 0; e_mwd = 0; e_mmask = 0; e_ifd = 0; e_lsd = 0;
      m_cyc++;
      return;
    end
    if (!m_busy) begin
      if (ls_req_valid_i && !m_skip_ls) begin
        m_busy = 1; m_ls = 1; m_drop = 0; m_acc = -1;
        e_maddr = ls_addr_i; e_mwe = ls_we_i; e_mwd = ls_wdata_i; e_mmask = ls_mask_i;
      end else if (if_req_valid_i && !if_flush_i && !m_skip_if) begin
        m_busy = 1; m_ls = 0; m_drop = 0; m_acc = -1;
        e_maddr = if_addr_i; e_mwe = 0; e_mmask = 8'h0f;
      end
    end else begin
      if (!m_ls && if_flush_i) m_drop = 1;
      if (m_acc < 0) begin
        if (mem_req_ready_i) m_acc = m_cyc;
      end else if (mem_resp_valid_i || (m_cyc - m_acc == TIMEOUT)) begin
        tmo = !mem_resp_valid_i;
        m_busy = 0;
        if (m_ls) begin
          nsl = 1; e_lsv = 1; e_lse = tmo;
          e_lsd = (tmo || e_mwe) ? 64'h0 : mem_rdata_i;
        end else begin
          nsi = 1;
          if (!m_drop) begin
            e_ifv = 1; e_ife = tmo; e_ifd = tmo ? 64'h0 : mem_rdata_i;
          end
        end
      end
    end
    m_skip_if = nsi; m_skip_ls = nsl;
    e_mval = m_busy && (m_acc < 0);
    m_cyc++;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk($sformatf("model_cyc%0d", m_cyc),
        256'({mem_req_valid_o, mem_addr_o, mem_we_o, mem_mask_o, (e_mwe ? mem_wdata_o : 64'h0),
              if_rdata_valid_o, if_rdata_o, if_err_o, ls_done_o, ls_rdata_o, ls_err_o}),
        256'({e_mval, e_maddr, e_mwe, e_mmask, (e_mwe ? e_mwd : 64'h0),
              e_ifv, e_ifd, e_ife, e_lsv, e_lsd, e_lse}));
  endtask

  // ctl = {rst, if_req, flush, ls_req, ls_we, ready, resp}; ef = {mem_valid, if_valid, ls_done, err}
  typedef struct {
    logic [6:0]  ctl;
    logic [31:0] iaddr, laddr;
    logic [63:0] wdata, rdata;
    logic [3:0]  ef;
    logic [31:0] maddr;
    logic [63:0] idat, ldat;
  } vec_t;

  function automatic vec_t V(input logic [6:0] c, input logic [31:0] ia, input logic [31:0] la,
                             input logic [63:0] wd, input logic [63:0] rd, input logic [3:0] ef,
                             input logic [31:0] ma, input logic [63:0] id, input logic [63:0] ld);
    vec_t v;
    v.ctl = c; v.iaddr = ia; v.laddr = la; v.wdata = wd; v.rdata = rd;
    v.ef = ef; v.maddr = ma; v.idat = id; v.ldat = ld;
    return v;
  endfunction

  vec_t vecs[$];
  int n;

  initial begin
    rst = 1'b1; if_req_valid_i = 1'b0; if_addr_i = '0; if_flush_i = 1'b0;
    ls_req_valid_i = 1'b0; ls_we_i = 1'b0; ls_addr_i = '0; ls_wdata_i = '0; ls_mask_i = 8'hff;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_rdata_i = '0;

    vecs.push_back(V(7'b1000000, ZA, ZA, Z, Z, 4'b0000, ZA, Z, Z));
    vecs.push_back(V(7'b0100010, IA, ZA, Z, Z, 4'b1000, IA, Z, Z));
    vecs.push_back(V(7'b0100010, IA, ZA, Z, Z, 4'b0000, IA, Z, Z));
    vecs.push_back(V(7'b0100011, IA, ZA, Z, 64'h13, 4'b0100, IA, 64'h13, Z));
    vecs.push_back(V(7'b0000010, IA, ZA, Z, Z, 4'b0000, IA, 64'h13, Z));
    vecs.push_back(V(7'b0101001, IA8, 32'h1000, Z, 64'hbad, 4'b1000, 32'h1000, 64'h13, Z));
    vecs.push_back(V(7'b0101011, IA8, 32'h1000, Z, 64'hbad, 4'b0000, 32'h1000, 64'h13, Z));
    vecs.push_back(V(7'b0101001, IA8, 32'h1000, Z, 64'h55, 4'b0010, 32'h1000, 64'h13, 64'h55));
    vecs.push_back(V(7'b0101000, IA8, 32'h1000, Z, Z, 4'b1000, IA8, 64'h13, 64'h55));
    vecs.push_back(V(7'b0100010, IA8, ZA, Z, Z, 4'b0000, IA8, 64'h13, 64'h55));
    vecs.push_back(V(7'b0100001, IA8, ZA, Z, 64'h77, 4'b0100, IA8, 64'h77, 64'h55));
    vecs.push_back(V(7'b0100000, IA8, ZA, Z, Z, 4'b0000, IA8, 64'h77, 64'h55));
    vecs.push_back(V(7'b0000000, IA8, ZA, Z, Z, 4'b0000, IA8, 64'h77, 64'h55));
    vecs.push_back(V(7'b0001100, ZA, 32'h2000, 64'hdead, Z, 4'b1000, 32'h2000, 64'h77, 64'h55));
    for (int i = 0; i < 4; i++)
      vecs.push_back(V(7'b0001100, ZA, 32'h3000, 64'hbeef, Z, 4'b1000, 32'h2000, 64'h77, 64'h55));
    vecs.push_back(V(7'b0001110, ZA, 32'h3000, 64'hbeef, Z, 4'b0000, 32'h2000, 64'h77, 64'h55));
    vecs.push_back(V(7'b0001101, ZA, 32'h3000, 64'hbeef, 64'h1234, 4'b0010, 32'h2000, 64'h77, Z));
    vecs.push_back(V(7'b0001100, ZA, 32'h3000, 64'hbeef, Z, 4'b0000, 32'h2000, 64'h77, Z));
    vecs.push_back(V(7'b0000000, ZA, ZA, Z, Z, 4'b0000, 32'h2000, 64'h77, Z));
    vecs.push_back(V(7'b0100000, IB, ZA, Z, Z, 4'b1000, IB, 64'h77, Z));
    vecs.push_back(V(7'b0100010, IB, ZA, Z, Z, 4'b0000, IB, 64'h77, Z));
    vecs.push_back(V(7'b0110000, IB, ZA, Z, Z, 4'b0000, IB, 64'h77, Z));
    vecs.push_back(V(7'b0100001, IC, ZA, Z, 64'h99, 4'b0000, IB, 64'h77, Z));
    vecs.push_back(V(7'b0100000, IC, ZA, Z, Z, 4'b0000, IB, 64'h77, Z));
    vecs.push_back(V(7'b0100000, IC, ZA, Z, Z, 4'b1000, IC, 64'h77, Z));
    vecs.push_back(V(7'b0100010, IC, ZA, Z, Z, 4'b0000, IC, 64'h77, Z));
    vecs.push_back(V(7'b0100001, IC, ZA, Z, 64'habc, 4'b0100, IC, 64'habc, Z));
    vecs.push_back(V(7'b0000000, ZA, ZA, Z, Z, 4'b0000, IC, 64'habc, Z));

    foreach (vecs[i]) begin
      {rst, if_req_valid_i, if_flush_i, ls_req_valid_i, ls_we_i, mem_req_ready_i, mem_resp_valid_i} = vecs[i].ctl;
      if_addr_i = vecs[i].iaddr; ls_addr_i = vecs[i].laddr;
      ls_wdata_i = vecs[i].wdata; mem_rdata_i = vecs[i].rdata;
      tick();
      chk($sformatf("row%0d", i),
          256'({mem_req_valid_o, if_rdata_valid_o, ls_done_o, (if_err_o | ls_err_o),
                mem_addr_o, if_rdata_o, ls_rdata_o}),
          256'({vecs[i].ef, vecs[i].maddr, vecs[i].idat, vecs[i].ldat}));
    end

    // Hung LSU read: error completion exactly 255 WAIT cycles after acceptance.
    ls_req_valid_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h4000;
    mem_req_ready_i = 1'b1; mem_resp_valid_i = 1'b0; mem_rdata_i = 64'hffff_ffff_ffff_ffff;
    tick();
    tick();
    mem_req_ready_i = 1'b0;
    n = 0;
    while (n < 300) begin
      n++;
      tick();
      if (ls_done_o) break;
    end
    chk("timeout_latency", 256'(n), 256'(TIMEOUT));
    chk("timeout_result", 256'({ls_done_o, ls_err_o, ls_rdata_o}), 256'({1'b1, 1'b1, 64'h0}));

    // Reset while an IF read waits; the late response must be ignored.
    ls_req_valid_i = 1'b0; if_req_valid_i = 1'b1; if_addr_i = IA + 32'h200;
    tick();
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("reset_in_wait",
        256'({mem_req_valid_o, mem_addr_o, mem_mask_o, if_rdata_valid_o, if_rdata_o, ls_done_o, ls_rdata_o, ls_err_o}),
        256'(0));
    rst = 1'b0; if_req_valid_i = 1'b0; mem_resp_valid_i = 1'b1; mem_rdata_i = 64'h5555;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("late_resp%0d", i), 256'({if_rdata_valid_o, ls_done_o, mem_req_valid_o}), 256'(0));
    end

    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 511) == 0);
      if (!if_req_valid_i || e_ifv) if_req_valid_i = ($urandom_range(0, 3) == 0);
      if (!ls_req_valid_i || e_lsv) ls_req_valid_i = ($urandom_range(0, 3) == 0);
      if_addr_i = $urandom;
      if_flush_i = ($urandom_range(0, 15) == 0);
      ls_we_i = ($urandom_range(0, 1) == 1);
      ls_addr_i = $urandom;
      ls_wdata_i = {$urandom, $urandom};
      ls_mask_i = 8'($urandom);
      mem_req_ready_i = ($urandom_range(0, 2) != 0);
      mem_resp_valid_i = ($urandom_range(0, 3) == 0);
      mem_rdata_i = {$urandom, $urandom};
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
